mult: RTL and testbench
=======================

# mult

Sequential signed 32×32 multiplier that fills the HI/LO register pair for `mult`. It uses radix-2 Booth recoding, one step per cycle. It sits beside the divider in the datapath and uses the same 2-bit `State` command / 2-bit status handshake with the main control unit, so the control FSM sequences both units the same way. The product is written to `Hi` (upper 32 bits) and `Lo` (lower 32 bits).

## Interface
Parameters: none. Width is fixed at 32 bits, iteration count at 32.

- `Clock`  in  1  — single clock; all state changes on the rising edge.
- `Reset`  in  1  — asynchronous, active-low (asserted at 0).
- `State`  in  2  — command from control: 00 neutral, 01 load, 10 multiply, 11 hold.
- `Multiplicand`  in  32  — signed operand; sampled only in load.
- `Multiplier`  in  32  — signed operand; sampled only in load.
- `Hi`  out  32  — product bits [63:32]; registered.
- `Lo`  out  32  — product bits [31:0]; registered.
- `MulttoControl`  out  2  — status to control: 00 neutral, 01 done; 10 and 11 are never driven.

## Operation
Internal registers:
- `A`: 33-bit accumulator, sign-extended, so that subtracting M = −2^31 cannot overflow.
- `Q`: 32-bit multiplier shift register.
- `Qm1`: 1-bit Booth history bit.
- `M`: 33-bit sign-extended multiplicand.
- `Counter`: 6-bit.

Command behaviour:
- **State 00 (neutral):**
  - `Counter` ← 0 and `MulttoControl` ← 00.
  - `Hi`/`Lo` hold the last product.
- **State 01 (load):**
  - `A` ← 0, `Q` ← `Multiplier`, `Qm1` ← 0, `M` ← sext(`Multiplicand`).
  - `Counter` ← 0 and `MulttoControl` ← 00.
  - Load restarts any operation in progress.
- **State 10 (multiply), while `Counter` < 32:**
  - Booth step on {`Q[0]`,`Qm1`}: 01 → A+M; 10 → A−M; 00/11 → A unchanged.
  - Then arithmetic right shift of the 66-bit {A,Q,Qm1} by one, with A[32] replicated.
  - `Counter` +1.
- **State 10, when `Counter` == 32:**
  - `Hi` ← A[31:0], `Lo` ← Q, `MulttoControl` ← 01.
  - Further cycles in state 10 leave all registers unchanged, and `MulttoControl` stays 01.
- **State 11 (hold):** no register changes.
- `Hi`/`Lo` never show partial products; they change only on the completion edge or on reset.
- The result is the exact signed 64-bit product for all operand pairs; there is no overflow status.

## Timing
- **Reset** (`Reset`=0, asynchronous): `Hi`=0, `Lo`=0, `MulttoControl`=00, `A`=0, `Q`=0, `Qm1`=0, `M`=0, `Counter`=0. Reset takes effect immediately and mid-operation, discarding the partial product.
- **Latency:** 1 load edge plus 33 rising edges in state 10. `MulttoControl`=01, `Hi` and `Lo` all become valid together after the 33rd edge.
- **Handshake:**
  - Control holds `State`=10 until it sees 01.
  - Control then drives 00 for at least one cycle, which clears the status.
  - Control must issue 01 before the next 10. A 10 issued without a fresh load resumes from the current `Counter`. If `Counter` is already 32, the result and status stay as they are.
- **Operand changes:** `Multiplicand` and `Multiplier` may change freely outside the load cycle.
- **Simultaneous events:** `Reset` dominates any `State` value.
- **Interrupted operation:** state 11 for any number of cycles mid-operation, then back to 10, completes with the correct product. Total latency increases by exactly the number of 11 cycles.

## Test plan
- Load 3 × 5, then 33 cycles in state 10 → `Hi`=0x00000000, `Lo`=0x0000000F, `MulttoControl`=01 on edge 33 and not before; `Hi`/`Lo` unchanged during edges 1–32.
- −7 × 6 (0xFFFFFFF9, 0x00000006) → `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFD6. Then `State`=00 → `MulttoControl`=00, `Hi`/`Lo` held.
- 0x80000000 × 0x80000000 → `Hi`=0x40000000, `Lo`=0x00000000. 0xFFFFFFFF × 0x80000000 → `Hi`=0x00000000, `Lo`=0x80000000.
- 0x7FFFFFFF × 0x7FFFFFFF → `Hi`=0x3FFFFFFF, `Lo`=0x00000001. 0 × 0x12345678 → `Hi`=0, `Lo`=0.
- Drive `Reset`=0 asynchronously, between clock edges, after 10 multiply cycles → all outputs 0 immediately. After release, load 2 × 3 → `Lo`=6 after 33 cycles.
- Insert 5 cycles of state 11 mid-operation, and reload via 01 partway through a second operation → both results correct. Done arrives exactly 38 multiply-or-hold edges after the first load, and exactly 33 state-10 edges after the reload.

Source files
------------

// File: rtl/mult.sv
// Sequential signed 32x32 radix-2 Booth multiplier producing the Hi/Lo pair.
// Sequenced by a 2-bit command from control and answering with a 2-bit status.
module mult (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  State,
   input  logic [31:0] Multiplicand,
   input  logic [31:0] Multiplier,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic [1:0]  MulttoControl
);

   typedef enum logic [1:0] {
      CMD_NEUTRAL = 2'b00,
      CMD_LOAD    = 2'b01,
      CMD_MULT    = 2'b10,
      CMD_HOLD    = 2'b11
   } cmd_e;

   localparam logic [5:0] ITERS = 6'd32;

   logic [32:0] a_q, a_d;
   logic [31:0] q_q, q_d;
   logic        qm1_q, qm1_d;
   logic [32:0] m_q, m_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [1:0]  stat_q, stat_d;
   logic [32:0] sum;
   cmd_e        cmd;

   assign cmd = cmd_e'(State);

   // Booth add/subtract ahead of the arithmetic shift
   always_comb begin
      sum = a_q;
      case ({q_q[0], qm1_q})
         2'b01:   sum = a_q + m_q;
         2'b10:   sum = a_q - m_q;
         default: sum = a_q;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      q_d    = q_q;
      qm1_d  = qm1_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      stat_d = stat_q;
      case (cmd)
         CMD_NEUTRAL: begin
            cnt_d  = '0;
            stat_d = 2'b00;
         end
         CMD_LOAD: begin
            a_d    = '0;
            q_d    = Multiplier;
            qm1_d  = 1'b0;
            m_d    = {Multiplicand[31], Multiplicand};
            cnt_d  = '0;
            stat_d = 2'b00;
         end
         CMD_MULT: begin
            if (cnt_q < ITERS) begin
               // {A,Q,Qm1} >>> 1 with the accumulator sign replicated
               a_d   = {sum[32], sum[32:1]};
               q_d   = {sum[0], q_q[31:1]};
               qm1_d = q_q[0];
               cnt_d = cnt_q + 6'd1;
            end else begin
               hi_d   = a_q[31:0];
               lo_d   = q_q;
               stat_d = 2'b01;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         a_q    <= '0;
         q_q    <= '0;
         qm1_q  <= 1'b0;
         m_q    <= '0;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         stat_q <= 2'b00;
      end else begin
         a_q    <= a_d;
         q_q    <= q_d;
         qm1_q  <= qm1_d;
         m_q    <= m_d;
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         stat_q <= stat_d;
      end
   end

   assign Hi            = hi_q;
   assign Lo            = lo_q;
   assign MulttoControl = stat_q;

endmodule

// File: tb/tb_mult.sv
// Randomized self-checking bench for mult against a cycle-count product model.
module tb_mult;

   logic        Clock;
   logic        Reset;
   logic [1:0]  State;
   logic [31:0] Multiplicand;
   logic [31:0] Multiplier;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic [1:0]  MulttoControl;

   int n_cmp = 0;
   int n_bad = 0;

   mult dut (
      .Clock(Clock), .Reset(Reset), .State(State),
      .Multiplicand(Multiplicand), .Multiplier(Multiplier),
      .Hi(Hi), .Lo(Lo), .MulttoControl(MulttoControl)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Model: product computed with plain 64-bit arithmetic at load time,
   // published after 32 counted steps plus the completion edge.
   logic [63:0] m_prod;
   logic [31:0] m_hi, m_lo;
   logic [1:0]  m_st;
   int          m_cnt;

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         m_prod = '0; m_hi = '0; m_lo = '0; m_st = 2'b00; m_cnt = 0;
      end else begin
         case (State)
            2'b00: begin m_cnt = 0; m_st = 2'b00; end
            2'b01: begin
               longint sa, sb;
               sa = longint'($signed(Multiplicand));
               sb = longint'($signed(Multiplier));
               m_prod = sa * sb;
               m_cnt  = 0;
               m_st   = 2'b00;
            end
            2'b10: begin
               if (m_cnt < 32) m_cnt++;
               else begin
                  m_hi = m_prod[63:32];
                  m_lo = m_prod[31:0];
                  m_st = 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      chk("model_hi", 64'(Hi), 64'(m_hi));
      chk("model_lo", 64'(Lo), 64'(m_lo));
      chk("model_st", 64'(MulttoControl), 64'(m_st));
   end

   task automatic do_load(input logic [31:0] a, input logic [31:0] b);
      @(negedge Clock);
      State = 2'b01; Multiplicand = a; Multiplier = b;
      @(negedge Clock);
      Multiplicand = $urandom; Multiplier = $urandom;
   endtask

   // Assumes called right after do_load (on a negedge); counts edges until done.
   task automatic run_to_done(output int edges);
      edges = 0;
      State = 2'b10;
      while (edges < 60) begin
         @(negedge Clock);
         edges++;
         if (MulttoControl == 2'b01) break;
      end
      if (MulttoControl != 2'b01) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout: no done after %0d edges", edges);
      end
   endtask

   task automatic mult_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
      int e;
      do_load(a, b);
      run_to_done(e);
      chk({nm, "_lat"}, 64'(e), 64'd33);
      chk({nm, "_prod"}, {Hi, Lo}, exp);
      State = 2'b00;
      @(negedge Clock);
      chk({nm, "_clr"}, 64'(MulttoControl), 64'd0);
      chk({nm, "_held"}, {Hi, Lo}, exp);
   endtask

   initial begin
      int e;
      logic [31:0] pool [6];
      logic [31:0] ra, rb;
      longint sa, sb;
      pool = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000001};

      Reset = 1'b0; State = 2'b00; Multiplicand = '0; Multiplier = '0;
      #1;
      chk("rst_out", {Hi, Lo}, 64'd0);
      chk("rst_st", 64'(MulttoControl), 64'd0);
      @(negedge Clock); @(negedge Clock);
      Reset = 1'b1;

      mult_op(32'd3, 32'd5, 64'h00000000_0000000F, "3x5");
      mult_op(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, "m7x6");
      mult_op(32'h80000000, 32'h80000000, 64'h40000000_00000000, "minxmin");
      mult_op(32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000, "m1xmin");
      mult_op(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, "maxxmax");
      mult_op(32'h0, 32'h12345678, 64'h0, "0xk");

      // asynchronous reset mid-operation
      do_load(32'h12345, 32'h6789A);
      State = 2'b10;
      repeat (10) @(negedge Clock);
      #2 Reset = 1'b0;
      #1;
      chk("arst_out", {Hi, Lo}, 64'd0);
      chk("arst_st", 64'(MulttoControl), 64'd0);
      @(negedge Clock);
      State = 2'b00;
      @(negedge Clock);
      Reset = 1'b1;
      mult_op(32'd2, 32'd3, 64'd6, "2x3");

      // hold cycles mid-operation
      do_load(32'hFFFF1234, 32'h00ABCDEF);
      State = 2'b10;
      repeat (10) @(negedge Clock);
      State = 2'b11;
      repeat (5) @(negedge Clock);
      run_to_done(e);
      chk("hold_lat", 64'(e + 15), 64'd38);
      sa = longint'($signed(32'hFFFF1234)); sb = longint'($signed(32'h00ABCDEF));
      chk("hold_prod", {Hi, Lo}, 64'(sa * sb));
      State = 2'b00;
      @(negedge Clock);

      // reload partway through
      do_load(32'd1000, 32'd1000);
      State = 2'b10;
      repeat (12) @(negedge Clock);
      do_load(32'hFFFFFFFE, 32'd21);
      run_to_done(e);
      chk("reload_lat", 64'(e), 64'd33);
      chk("reload_prod", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFD6);
      State = 2'b00;
      @(negedge Clock);

      // randomized operands, with corner values mixed in
      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(3) == 0) ? pool[$urandom_range(5)] : $urandom;
         rb = ($urandom_range(3) == 0) ? pool[$urandom_range(5)] : $urandom;
         sa = longint'($signed(ra)); sb = longint'($signed(rb));
         mult_op(ra, rb, 64'(sa * sb), "rand");
         // linger in done state occasionally: result and status must hold
         if (i % 5 == 0) begin
            do_load(ra, rb);
            run_to_done(e);
            State = 2'b10;
            repeat (3) @(negedge Clock);
            chk("linger_prod", {Hi, Lo}, 64'(sa * sb));
            chk("linger_st", 64'(MulttoControl), 64'd1);
            State = 2'b00;
            @(negedge Clock);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
